// File: rtl/bsram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bsram_arb_pkg
//  Description : Shared types and constants for the BSRAM two-port arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
package bsram_arb_pkg;

   // Controller phases: zero-fill of the memory, then normal arbitration
   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Requester identifiers as held in the last-granted register
   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

endpackage : bsram_arb_pkg
`default_nettype wire

// File: rtl/bsram_arb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-input round-robin arbiter with same-cycle grant.
//                On contention the port not granted last wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
   import bsram_arb_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_req_a,
   input  logic i_req_b,
   output logic o_gnt_a,
   output logic o_gnt_b
);

   logic r_last;
   logic w_gnt_a;
   logic w_gnt_b;

   // Combinational grant: a lone requester always wins, contention uses r_last
   always_comb begin
      w_gnt_a = i_en & i_req_a & (~i_req_b | (r_last == PORT_B));
      w_gnt_b = i_en & i_req_b & (~i_req_a | (r_last == PORT_A));
   end

   // Last-granted register moves only when a grant is actually issued
   always_ff @(posedge clk) begin
      if (reset) begin
         r_last <= PORT_B;
      end else if (w_gnt_a) begin
         r_last <= PORT_A;
      end else if (w_gnt_b) begin
         r_last <= PORT_B;
      end
   end

   assign o_gnt_a = w_gnt_a;
   assign o_gnt_b = w_gnt_b;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/bsram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : bsram_arb
//  Description : Shares one single-port BSRAM (bypass output) between a CPU
//                data port (A) and a loader port (B). Optionally zero-fills
//                the whole memory after reset before accepting requests.
//  Revision    : 1.0 - initial release
// ============================================================================
module bsram_arb
   import bsram_arb_pkg::*;
#(
   parameter int AW             = 11,
   parameter int DW             = 8,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          a_req,
   input  logic          a_we,
   input  logic [AW-1:0] a_addr,
   input  logic [DW-1:0] a_wdata,
   input  logic          b_req,
   input  logic          b_we,
   input  logic [AW-1:0] b_addr,
   input  logic [DW-1:0] b_wdata,
   output logic          a_gnt,
   output logic          b_gnt,
   output logic          a_rvalid,
   output logic          b_rvalid,
   output logic [DW-1:0] a_rdata,
   output logic [DW-1:0] b_rdata,
   output logic          init_done,
   output logic          mem_ce,
   output logic          mem_oce,
   output logic          mem_wre,
   output logic [AW-1:0] mem_ad,
   output logic [DW-1:0] mem_din,
   output logic          mem_reset,
   input  logic [DW-1:0] mem_dout
);

   localparam logic [AW-1:0] c_CLR_LAST = {AW{1'b1}};
   localparam logic [AW-1:0] c_CLR_ONE  = {{(AW-1){1'b0}}, 1'b1};

   state_t        r_state;
   logic [AW-1:0] r_clr_cnt;
   logic          r_init_done;
   logic          r_a_rvalid;
   logic          r_b_rvalid;
   logic          w_run;
   logic          w_clear;

   // Grants are suppressed while reset is held, even if the state is RUN
   assign w_run   = (r_state == ST_RUN)   & ~reset;
   assign w_clear = (r_state == ST_CLEAR) & ~reset;

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset   (reset),
      .i_en    (w_run),
      .i_req_a (a_req),
      .i_req_b (b_req),
      .o_gnt_a (a_gnt),
      .o_gnt_b (b_gnt)
   );

   // Clear sequencer: walk every address once, then hand over to arbitration
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         r_clr_cnt   <= '0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               r_clr_cnt <= r_clr_cnt + c_CLR_ONE;
               if (r_clr_cnt == c_CLR_LAST) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
               end
            end
            default: begin
               r_init_done <= 1'b1;
            end
         endcase
      end
   end

   // Read-data valid follows a granted read by exactly one cycle
   always_ff @(posedge clk) begin
      if (reset) begin
         r_a_rvalid <= 1'b0;
         r_b_rvalid <= 1'b0;
      end else begin
         r_a_rvalid <= a_gnt & ~a_we;
         r_b_rvalid <= b_gnt & ~b_we;
      end
   end

   // Memory port mux: clear writes, then the granted requester, else idle
   always_comb begin
      mem_ce  = 1'b0;
      mem_wre = 1'b0;
      mem_ad  = a_addr;
      mem_din = a_wdata;
      if (w_clear) begin
         mem_ce  = 1'b1;
         mem_wre = 1'b1;
         mem_ad  = r_clr_cnt;
         mem_din = '0;
      end else if (a_gnt) begin
         mem_ce  = 1'b1;
         mem_wre = a_we;
         mem_ad  = a_addr;
         mem_din = a_wdata;
      end else if (b_gnt) begin
         mem_ce  = 1'b1;
         mem_wre = b_we;
         mem_ad  = b_addr;
         mem_din = b_wdata;
      end
   end

   // A reset arriving right after a read grant must hide that read's valid
   assign a_rvalid  = r_a_rvalid & ~reset;
   assign b_rvalid  = r_b_rvalid & ~reset;
   assign a_rdata   = mem_dout;
   assign b_rdata   = mem_dout;
   assign init_done = r_init_done;
   assign mem_oce   = 1'b1;
   assign mem_reset = reset;

endmodule : bsram_arb
`default_nettype wire

// File: tb/tb_bsram_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bsram_arb
//  Description : Scoreboard bench for bsram_arb with a behavioural BSRAM
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bsram_arb;

   localparam int AW = 11;
   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          a_req, a_we, b_req, b_we;
   logic [AW-1:0] a_addr, b_addr;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          init_done;
   logic          mem_ce, mem_oce, mem_wre, mem_reset;
   logic [AW-1:0] mem_ad;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   typedef struct {
      logic [7:0] d;
      int         c;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];

   logic [DW-1:0] mem_arr [0:(1<<AW)-1];

   bsram_arb #(.AW(AW), .DW(DW), .CLEAR_ON_RESET(1)) dut (
      .clk       (clk),
      .reset     (reset),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .a_gnt     (a_gnt),
      .b_gnt     (b_gnt),
      .a_rvalid  (a_rvalid),
      .b_rvalid  (b_rvalid),
      .a_rdata   (a_rdata),
      .b_rdata   (b_rdata),
      .init_done (init_done),
      .mem_ce    (mem_ce),
      .mem_oce   (mem_oce),
      .mem_wre   (mem_wre),
      .mem_ad    (mem_ad),
      .mem_din   (mem_din),
      .mem_reset (mem_reset),
      .mem_dout  (mem_dout)
   );

   always #5 clk = ~clk;

   // Cycle counter used to check read latency
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural BSRAM in bypass mode: read data one cycle after the address
   initial begin
      for (int i = 0; i < (1 << AW); i++) mem_arr[i] = 8'hFF;
      mem_dout = 8'hEE;
   end
   always @(posedge clk) begin
      if (mem_ce) begin
         if (mem_wre) mem_arr[mem_ad] <= mem_din;
         else         mem_dout        <= mem_arr[mem_ad];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: pop expectations whenever a read-data valid is presented
   always @(negedge clk) begin : mon
      exp_t e;
      if (a_rvalid === 1'b1) begin
         if (qa.size() == 0) chk("a_rvalid_unexpected", 32'd1, 32'd0);
         else begin
            e = qa.pop_front();
            chk("a_rdata", {24'd0, a_rdata}, {24'd0, e.d});
            chk("a_rvalid_cycle", cyc, e.c);
         end
      end
      if (b_rvalid === 1'b1) begin
         if (qb.size() == 0) chk("b_rvalid_unexpected", 32'd1, 32'd0);
         else begin
            e = qb.pop_front();
            chk("b_rdata", {24'd0, b_rdata}, {24'd0, e.d});
            chk("b_rvalid_cycle", cyc, e.c);
         end
      end
   end

   // One cycle of stimulus with hand-computed grants and read data
   task automatic acc(input string nm,
                      input logic ra, input logic wa, input logic [10:0] aa, input logic [7:0] da,
                      input logic rb, input logic wb, input logic [10:0] ab, input logic [7:0] db,
                      input logic ega, input logic egb, input logic [7:0] xa, input logic [7:0] xb);
      a_req = ra; a_we = wa; a_addr = aa; a_wdata = da;
      b_req = rb; b_we = wb; b_addr = ab; b_wdata = db;
      @(negedge clk);
      chk({nm, "_a_gnt"}, a_gnt, ega);
      chk({nm, "_b_gnt"}, b_gnt, egb);
      if (ega) begin
         chk({nm, "_mem_ce"},  mem_ce,  1);
         chk({nm, "_mem_wre"}, mem_wre, wa);
         chk({nm, "_mem_ad"},  mem_ad,  aa);
         if (wa) chk({nm, "_mem_din"}, mem_din, da);
         else    qa.push_back('{xa, cyc + 1});
      end else if (egb) begin
         chk({nm, "_mem_ce"},  mem_ce,  1);
         chk({nm, "_mem_wre"}, mem_wre, wb);
         chk({nm, "_mem_ad"},  mem_ad,  ab);
         if (wb) chk({nm, "_mem_din"}, mem_din, db);
         else    qb.push_back('{xb, cyc + 1});
      end else begin
         chk({nm, "_idle_ce"},  mem_ce,  0);
         chk({nm, "_idle_wre"}, mem_wre, 0);
      end
      @(posedge clk); #1;
      a_req = 1'b0; b_req = 1'b0;
   endtask

   // Walk a full clear window, counting any cycle that breaks the clear rules
   task automatic clear_window(input string nm);
      int bad;
      bad = 0;
      for (int k = 0; k < (1 << AW); k++) begin
         @(negedge clk);
         if (init_done !== 1'b0 || a_gnt !== 1'b0 || b_gnt !== 1'b0 ||
             mem_ce !== 1'b1 || mem_wre !== 1'b1 || mem_ad !== 11'(k) || mem_din !== 8'h00)
            bad++;
      end
      chk({nm, "_violations"}, bad, 0);
   endtask

   initial begin
      reset = 1'b1;
      a_req = 1'b1; a_we = 1'b0; a_addr = 11'd3; a_wdata = 8'h00;
      b_req = 1'b0; b_we = 1'b0; b_addr = 11'd0; b_wdata = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_init_done", init_done, 0);
      chk("rst_a_gnt",     a_gnt,     0);
      chk("rst_mem_ce",    mem_ce,    0);
      chk("rst_mem_wre",   mem_wre,   0);
      chk("rst_a_rvalid",  a_rvalid,  0);
      chk("rst_mem_reset", mem_reset, 1);
      chk("rst_mem_oce",   mem_oce,   1);

      // Clear with B requesting throughout; B must wait for the first RUN cycle
      @(posedge clk); #1;
      reset = 1'b0; a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 11'd5;
      clear_window("clear1");
      @(negedge clk);
      chk("first_run_init_done", init_done, 1);
      chk("first_run_b_gnt",     b_gnt,     1);
      if (b_gnt === 1'b1) qb.push_back('{8'h00, cyc + 1});
      @(posedge clk); #1;
      b_req = 1'b0;

      // Back-to-back readback of cleared memory
      acc("rd0",    1, 0, 11'd0,    8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      acc("rd1023", 1, 0, 11'd1023, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      acc("rd2047", 1, 0, 11'd2047, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);

      // Write then read of the same address on consecutive grants
      acc("wr010",  1, 1, 11'h010, 8'h5A, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      acc("rd010",  1, 0, 11'h010, 8'h00, 0, 0, 0, 0, 1, 0, 8'h5A, 8'h00);

      // Seed distinct data, leaving last-granted = B
      acc("wr021",  1, 1, 11'h021, 8'hA1, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      acc("wr022",  0, 0, 0, 0, 1, 1, 11'h022, 8'hB2, 0, 1, 8'h00, 8'h00);

      // Contention: A, B, A, B
      acc("both0", 1, 0, 11'h021, 0, 1, 0, 11'h022, 0, 1, 0, 8'hA1, 8'hB2);
      acc("both1", 1, 0, 11'h021, 0, 1, 0, 11'h022, 0, 0, 1, 8'hA1, 8'hB2);
      acc("both2", 1, 0, 11'h021, 0, 1, 0, 11'h022, 0, 1, 0, 8'hA1, 8'hB2);
      acc("both3", 1, 0, 11'h021, 0, 1, 0, 11'h022, 0, 0, 1, 8'hA1, 8'hB2);

      // Last-granted holds across idle cycles: after a lone A grant, B wins next
      acc("lone_a", 1, 0, 11'h021, 0, 0, 0, 0, 0, 1, 0, 8'hA1, 8'h00);
      acc("idle0",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      acc("idle1",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      acc("both4", 1, 0, 11'h021, 0, 1, 0, 11'h022, 0, 0, 1, 8'hA1, 8'hB2);

      repeat (3) @(posedge clk);
      #1;
      chk("drain1_qa", qa.size(), 0);
      chk("drain1_qb", qb.size(), 0);

      // Read granted, then reset next cycle: the read's valid must not appear
      a_req = 1'b1; a_we = 1'b0; a_addr = 11'h021;
      @(negedge clk);
      chk("pre_rst_a_gnt", a_gnt, 1);
      @(posedge clk); #1;
      reset = 1'b1; a_req = 1'b0;
      @(negedge clk);
      chk("rst_drop_a_rvalid", a_rvalid, 0);

      // Restart clear and interrupt it at clr_cnt = 700
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k <= 700; k++) @(negedge clk);
      chk("mid_clear_ad700", mem_ad, 11'd700);
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_mem_ce",    mem_ce,    0);
      chk("mid_rst_init_done", init_done, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      clear_window("clear2");
      @(negedge clk);
      chk("clear2_init_done", init_done, 1);
      @(posedge clk); #1;

      // Earlier write is gone after the second clear
      acc("rd010_after", 1, 0, 11'h010, 8'h00, 0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      repeat (3) @(posedge clk);
      #1;
      chk("drain2_qa", qa.size(), 0);
      chk("drain2_qb", qb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bsram_arb
`default_nettype wire

// File: doc/bsram_arb.md
BSRAM_ARB -- requirements
Module: bsram_arb

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter AW, default 11, meaning BSRAM address width (2048 words).
REQ-002 The block SHALL have parameter DW, default 8, meaning BSRAM data width.
REQ-003 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning zero-fill the BSRAM after reset when 1.

Ports (name, direction, width, meaning):
REQ-004 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-006 The block SHALL have ports a_req / b_req, input, 1 each, access request from requester A (CPU data) / B (loader).
REQ-007 The block SHALL have ports a_we / b_we, input, 1 each, 1 = write, 0 = read.
REQ-008 The block SHALL have ports a_addr / b_addr, input, AW each, word address.
REQ-009 The block SHALL have ports a_wdata / b_wdata, input, DW each, write data.
REQ-010 The block SHALL have ports a_gnt / b_gnt, output, 1 each, combinational acceptance; the request is consumed this cycle.
REQ-011 The block SHALL have ports a_rvalid / b_rvalid, output, 1 each, read data valid.
REQ-012 The block SHALL have ports a_rdata / b_rdata, output, DW each, read data, meaningful only while the matching rvalid is 1.
REQ-013 The block SHALL have port init_done, output, 1, high once the clear has finished (or immediately when CLEAR_ON_RESET = 0).
REQ-014 The block SHALL have ports mem_ce, mem_oce, mem_wre, output, 1 each; mem_ad, output, AW; mem_din, output, DW; these drive the BSRAM.
REQ-015 The block SHALL have port mem_reset, output, 1, BSRAM output-register reset, equal to reset.
REQ-016 The block SHALL have port mem_dout, input, DW, BSRAM read data in bypass mode, valid one cycle after the address edge.

Function
REQ-017 The block SHALL have exactly two FSM states, CLEAR and RUN; reset enters CLEAR if CLEAR_ON_RESET = 1, else RUN.
REQ-018 In CLEAR, the block SHALL drive mem_ce = 1, mem_wre = 1, mem_din = 0 and mem_ad = clr_cnt; clr_cnt increments from 0 each cycle.
REQ-019 When clr_cnt = 2^AW-1, the block SHALL move to RUN on the next edge; init_done rises on that same edge (2^AW cycles after reset deasserts).
REQ-020 In CLEAR, a_gnt and b_gnt SHALL be 0 and requests SHALL remain pending, with no loss.
REQ-021 In RUN, with only one requester active, the block SHALL grant that requester in the same cycle.
REQ-022 In RUN, with both requesters active, the block SHALL grant the port not granted last (round-robin); after reset the last-granted register is B, so A wins first.
REQ-023 The last-granted register SHALL update only on a grant.
REQ-024 On a grant, the block SHALL drive mem_ce = 1, mem_wre = x_we, mem_ad = x_addr and mem_din = x_wdata from the winner, combinationally.
REQ-025 When there is no grant, the block SHALL drive mem_ce = 0 and mem_wre = 0.
REQ-026 mem_oce SHALL be held at 1.
REQ-027 A granted read SHALL assert x_rvalid exactly one cycle later for one cycle, with x_rdata = mem_dout; a granted write SHALL produce no rvalid.
REQ-028 The block SHALL sustain throughput of one access per cycle; back-to-back reads overlap, with the rvalid of access N coinciding with the grant of access N+1.
REQ-029 Write followed by read of the same address on consecutive grants SHALL return the new data.
REQ-030 Same-port repeat requests with the other port idle SHALL all be granted, with no forced bubble.

Reset
REQ-031 While reset = 1 at an edge, the block SHALL set init_done = 0, a_rvalid = b_rvalid = 0, clr_cnt = 0, last-granted = B and state = CLEAR (or RUN per REQ-017).
REQ-032 During reset, the block SHALL hold a_gnt = b_gnt = 0 and mem_ce = mem_wre = 0.
REQ-033 Reset mid-CLEAR SHALL restart the clear from address 0.
REQ-034 Reset during RUN SHALL drop any pending rvalid.

Structure
REQ-035 A shared package SHALL hold the state enum {CLEAR, RUN} and the port-id constants PORT_A / PORT_B.
REQ-036 The two-input round-robin grant logic SHALL be one sub-module, rr_arb2.
REQ-037 bsram_arb SHALL be instantiated beside bsram8k and connect directly to it.

Verification
REQ-038 Reset then idle SHALL give init_done = 0 for 2048 cycles then 1, and a bench readback of addresses 0, 1023 and 2047 SHALL return 0x00.
REQ-039 A writes 0x5A to 0x010, then reads 0x010 next cycle, SHALL give a_rvalid one cycle after the read grant with a_rdata = 0x5A.
REQ-040 A and B both requesting reads for 4 cycles SHALL produce grants A, B, A, B and rvalids alternating one cycle later.
REQ-041 b_req held high during CLEAR SHALL give b_gnt = 0 until the first RUN cycle, then b_gnt = 1.
REQ-042 Reset asserted at clr_cnt = 700 for one cycle SHALL restart the clear, with init_done rising 2048 cycles after reset deasserts.
REQ-043 A read granted, then reset in the next cycle, SHALL leave a_rvalid = 0.
